// File: rtl/fma_write_buffer.sv
// Packs per-beat FMA result words into memory-line-wide words held in two
// ping-pong slots, and presents each completed line with a valid/ack handshake.
module fma_write_buffer #(
  parameter int FMA_COUNT  = 2,
  parameter int WORD_WIDTH = 16,
  parameter int PHRASES    = 3,
  parameter int LINE_WIDTH = 96
) (
  input  logic                            clk_in,
  input  logic                            rst_n_in,
  input  logic [FMA_COUNT*WORD_WIDTH-1:0] fma_c_in,
  input  logic [FMA_COUNT-1:0]            fma_valid_in,
  input  logic                            flush_in,
  input  logic                            line_ack_in,
  output logic [LINE_WIDTH-1:0]           line_out,
  output logic                            line_valid_out,
  output logic [1:0]                      lines_pending_out,
  output logic                            overflow_out,
  output logic                            error_out
);

  localparam int PHRASE_WIDTH = FMA_COUNT * WORD_WIDTH;
  localparam int CNT_WIDTH    = $clog2(PHRASES + 1);
  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(PHRASES);

  logic [LINE_WIDTH-1:0] slot_data [2];
  logic [LINE_WIDTH-1:0] data_nxt  [2];
  logic [1:0]            slot_full;
  logic [1:0]            full_nxt;
  logic                  wr_ptr, wr_nxt;
  logic                  rd_ptr, rd_nxt;
  logic [CNT_WIDTH-1:0]  cnt, cnt_nxt;
  logic                  ack_fire;
  logic                  beat_ok;
  logic                  beat_partial;
  logic                  drop;
  logic [LINE_WIDTH-1:0] out_nxt;
  logic                  valid_nxt;
  logic [1:0]            pending_nxt;

  // The ack is applied before the beat so a freed slot can absorb a beat in the
  // same cycle; the output register sees post-ack state but pre-fill state,
  // which gives the one-cycle completion latency and back-to-back lines.
  always_comb begin
    ack_fire     = line_ack_in && line_valid_out;
    beat_ok      = &fma_valid_in;
    beat_partial = (|fma_valid_in) && !beat_ok;
    data_nxt     = slot_data;
    full_nxt     = slot_full;
    wr_nxt       = wr_ptr;
    rd_nxt       = rd_ptr;
    cnt_nxt      = cnt;
    drop         = 1'b0;

    if (ack_fire) begin
      full_nxt[rd_ptr] = 1'b0;
      data_nxt[rd_ptr] = '0;
      rd_nxt           = ~rd_ptr;
    end

    out_nxt   = data_nxt[rd_nxt];
    valid_nxt = full_nxt[rd_nxt];

    if (beat_ok) begin
      if (full_nxt[wr_ptr]) begin
        drop = 1'b1;
      end else begin
        for (int p = 0; p < PHRASES; p++) begin
          if (cnt == CNT_WIDTH'(p)) begin
            data_nxt[wr_ptr][p*PHRASE_WIDTH +: PHRASE_WIDTH] = fma_c_in;
          end
        end
        cnt_nxt = cnt + CNT_WIDTH'(1);
      end
    end

    if ((cnt_nxt == LAST_CNT) || (flush_in && (cnt_nxt != '0))) begin
      full_nxt[wr_ptr] = 1'b1;
      cnt_nxt          = '0;
      wr_nxt           = ~wr_ptr;
    end

    pending_nxt = {1'b0, full_nxt[0]} + {1'b0, full_nxt[1]};
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      slot_data[0]      <= '0;
      slot_data[1]      <= '0;
      slot_full         <= '0;
      wr_ptr            <= 1'b0;
      rd_ptr            <= 1'b0;
      cnt               <= '0;
      line_out          <= '0;
      line_valid_out    <= 1'b0;
      lines_pending_out <= '0;
      overflow_out      <= 1'b0;
      error_out         <= 1'b0;
    end else begin
      slot_data[0]      <= data_nxt[0];
      slot_data[1]      <= data_nxt[1];
      slot_full         <= full_nxt;
      wr_ptr            <= wr_nxt;
      rd_ptr            <= rd_nxt;
      cnt               <= cnt_nxt;
      line_out          <= out_nxt;
      line_valid_out    <= valid_nxt;
      lines_pending_out <= pending_nxt;
      if (drop) begin
        overflow_out <= 1'b1;
      end
      if (beat_partial) begin
        error_out <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fma_write_buffer.sv
// Directed self-checking bench for fma_write_buffer: packing, ping-pong,
// overflow, same-cycle ack, flush, partial-valid error and async reset.
module tb_fma_write_buffer;

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic [31:0] fma_c_in;
  logic [1:0]  fma_valid_in;
  logic        flush_in;
  logic        line_ack_in;
  logic [95:0] line_out;
  logic        line_valid_out;
  logic [1:0]  lines_pending_out;
  logic        overflow_out;
  logic        error_out;

  int compareCount  = 0;
  int mismatchCount = 0;

  localparam logic [95:0] LINE_BASIC = 96'h0C01_0C00_0801_0800_0401_0400;
  localparam logic [95:0] LINE_A     = 96'h0006_0005_0004_0003_0002_0001;
  localparam logic [95:0] LINE_B     = 96'h0016_0015_0014_0013_0012_0011;
  localparam logic [95:0] LINE_C     = 96'h0026_0025_0024_0023_0022_0021;
  localparam logic [95:0] LINE_D     = 96'h0036_0035_0034_0033_0032_0031;
  localparam logic [95:0] LINE_E     = 96'h0046_0045_0044_0043_0042_0041;

  fma_write_buffer #(
    .FMA_COUNT(2), .WORD_WIDTH(16), .PHRASES(3), .LINE_WIDTH(96)
  ) dut (
    .clk_in           (clk_in),
    .rst_n_in         (rst_n_in),
    .fma_c_in         (fma_c_in),
    .fma_valid_in     (fma_valid_in),
    .flush_in         (flush_in),
    .line_ack_in      (line_ack_in),
    .line_out         (line_out),
    .line_valid_out   (line_valid_out),
    .lines_pending_out(lines_pending_out),
    .overflow_out     (overflow_out),
    .error_out        (error_out)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("[TB] FAIL timeout: simulation did not finish, got running required finished");
    $fatal(1, "[TB] timeout");
  end

  task automatic checkOutput(input string tag, input logic [95:0] actual, input logic [95:0] expected);
    compareCount++;
    if (actual !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  // Drives one cycle of inputs from a negedge and returns at the next negedge.
  task automatic applyStimulus(input logic [31:0] c, input logic [1:0] v, input logic fl, input logic ak);
    fma_c_in     = c;
    fma_valid_in = v;
    flush_in     = fl;
    line_ack_in  = ak;
    @(negedge clk_in);
    fma_c_in     = '0;
    fma_valid_in = '0;
    flush_in     = 1'b0;
    line_ack_in  = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(32'h0, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic beat(input logic [31:0] c);
    applyStimulus(c, 2'b11, 1'b0, 1'b0);
  endtask

  task automatic ack();
    applyStimulus(32'h0, 2'b00, 1'b0, 1'b1);
  endtask

  task automatic fillAB();
    beat(32'h0002_0001); beat(32'h0004_0003); beat(32'h0006_0005);
    beat(32'h0012_0011); beat(32'h0014_0013); beat(32'h0016_0015);
  endtask

  task automatic doReset();
    @(negedge clk_in);
    rst_n_in = 1'b0;
    @(negedge clk_in);
    rst_n_in = 1'b1;
  endtask

  initial begin
    rst_n_in     = 1'b0;
    fma_c_in     = '0;
    fma_valid_in = '0;
    flush_in     = 1'b0;
    line_ack_in  = 1'b0;
    repeat (2) @(negedge clk_in);
    checkOutput("rst_line", line_out, 96'h0);
    checkOutput("rst_valid", {95'h0, line_valid_out}, 96'h0);
    checkOutput("rst_pending", {94'h0, lines_pending_out}, 96'h0);
    checkOutput("rst_overflow", {95'h0, overflow_out}, 96'h0);
    checkOutput("rst_error", {95'h0, error_out}, 96'h0);
    rst_n_in = 1'b1;
    @(negedge clk_in);

    $display("[TB] basic pack");
    beat(32'h0401_0400); beat(32'h0801_0800); beat(32'h0C01_0C00);
    checkOutput("basic_latency_valid", {95'h0, line_valid_out}, 96'h0);
    checkOutput("basic_pending", {94'h0, lines_pending_out}, 96'h1);
    idle(1);
    checkOutput("basic_valid", {95'h0, line_valid_out}, 96'h1);
    checkOutput("basic_line", line_out, LINE_BASIC);
    for (int i = 0; i < 5; i++) begin
      idle(1);
      checkOutput("basic_hold_line", line_out, LINE_BASIC);
      checkOutput("basic_hold_valid", {95'h0, line_valid_out}, 96'h1);
    end
    ack();
    checkOutput("basic_ack_valid", {95'h0, line_valid_out}, 96'h0);
    checkOutput("basic_ack_pending", {94'h0, lines_pending_out}, 96'h0);
    ack();
    checkOutput("idle_ack_pending", {94'h0, lines_pending_out}, 96'h0);

    $display("[TB] ping-pong");
    fillAB();
    idle(1);
    checkOutput("pp_pending2", {94'h0, lines_pending_out}, 96'h2);
    checkOutput("pp_first_line", line_out, LINE_A);
    ack();
    checkOutput("pp_b2b_valid", {95'h0, line_valid_out}, 96'h1);
    checkOutput("pp_second_line", line_out, LINE_B);
    checkOutput("pp_pending1", {94'h0, lines_pending_out}, 96'h1);
    ack();
    checkOutput("pp_done_valid", {95'h0, line_valid_out}, 96'h0);
    checkOutput("pp_done_pending", {94'h0, lines_pending_out}, 96'h0);

    $display("[TB] overflow");
    fillAB();
    checkOutput("ovf_before", {95'h0, overflow_out}, 96'h0);
    beat(32'hDEAD_BEEF);
    checkOutput("ovf_set", {95'h0, overflow_out}, 96'h1);
    checkOutput("ovf_pending", {94'h0, lines_pending_out}, 96'h2);
    idle(1);
    checkOutput("ovf_line_a", line_out, LINE_A);
    ack();
    checkOutput("ovf_line_b", line_out, LINE_B);
    ack();
    checkOutput("ovf_drain_pending", {94'h0, lines_pending_out}, 96'h0);
    checkOutput("ovf_sticky", {95'h0, overflow_out}, 96'h1);

    $display("[TB] same-cycle ack");
    doReset();
    checkOutput("reset_clears_ovf", {95'h0, overflow_out}, 96'h0);
    fillAB();
    idle(1);
    applyStimulus(32'h0022_0021, 2'b11, 1'b0, 1'b1);
    checkOutput("sc_no_overflow", {95'h0, overflow_out}, 96'h0);
    checkOutput("sc_pending", {94'h0, lines_pending_out}, 96'h1);
    checkOutput("sc_line_b", line_out, LINE_B);
    beat(32'h0024_0023); beat(32'h0026_0025);
    checkOutput("sc_pending2", {94'h0, lines_pending_out}, 96'h2);
    ack();
    checkOutput("sc_line_c", line_out, LINE_C);
    ack();
    checkOutput("sc_drain", {94'h0, lines_pending_out}, 96'h0);

    $display("[TB] flush");
    beat(32'h1234_5678);
    applyStimulus(32'h0, 2'b00, 1'b1, 1'b0);
    checkOutput("flush_pending", {94'h0, lines_pending_out}, 96'h1);
    idle(1);
    checkOutput("flush_valid", {95'h0, line_valid_out}, 96'h1);
    checkOutput("flush_line", line_out, 96'h0000_0000_0000_0000_1234_5678);
    applyStimulus(32'h0, 2'b00, 1'b1, 1'b0);
    idle(1);
    checkOutput("flush_empty_pending", {94'h0, lines_pending_out}, 96'h1);
    checkOutput("flush_empty_line", line_out, 96'h0000_0000_0000_0000_1234_5678);
    ack();
    applyStimulus(32'h0BAD_F00D, 2'b11, 1'b1, 1'b0);
    idle(1);
    checkOutput("beat_flush_line", line_out, 96'h0000_0000_0000_0000_0BAD_F00D);
    ack();
    checkOutput("beat_flush_drain", {94'h0, lines_pending_out}, 96'h0);

    $display("[TB] partial valid and reset");
    applyStimulus(32'hFFFF_FFFF, 2'b01, 1'b0, 1'b0);
    checkOutput("err_set", {95'h0, error_out}, 96'h1);
    checkOutput("err_pending", {94'h0, lines_pending_out}, 96'h0);
    beat(32'h0032_0031); beat(32'h0034_0033);
    checkOutput("err_cnt_unchanged", {94'h0, lines_pending_out}, 96'h0);
    beat(32'h0036_0035);
    idle(1);
    checkOutput("err_line_d", line_out, LINE_D);
    beat(32'h0052_0051); beat(32'h0054_0053);
    #2 rst_n_in = 1'b0;
    #1;
    checkOutput("arst_line", line_out, 96'h0);
    checkOutput("arst_valid", {95'h0, line_valid_out}, 96'h0);
    checkOutput("arst_pending", {94'h0, lines_pending_out}, 96'h0);
    checkOutput("arst_error", {95'h0, error_out}, 96'h0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    idle(4);
    checkOutput("arst_no_line", {95'h0, line_valid_out}, 96'h0);
    beat(32'h0042_0041); beat(32'h0044_0043); beat(32'h0046_0045);
    idle(1);
    checkOutput("arst_fresh_valid", {95'h0, line_valid_out}, 96'h1);
    checkOutput("arst_fresh_line", line_out, LINE_E);

    $display("[TB] *** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
